fp16_norm_round: RTL
====================

Name: fp16_norm_round

Overview:
- Downstream stage of the fp16 multiplier datapath. Consumes the raw product: sign, unbiased exponent sum, and 22-bit significand product (11b x 11b, hidden bits included).
- Normalizes, rounds to nearest-even, applies overflow/underflow/special handling, and emits a packed IEEE-754 binary16 result.
- Two-stage pipeline with valid/ready flow control on both sides.

Parameters:
- MANT_W, 22, width of incoming significand product (format 2.20).
- EXP_W, 7, width of signed unbiased exponent sum input.
- BIAS, 15, binary16 exponent bias.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream product valid.
- in_ready  out  1  block can accept this cycle.
- in_sign  in  1  product sign.
- in_exp  in  EXP_W  signed unbiased exponent sum, (ea-15)+(eb-15).
- in_mant  in  MANT_W  significand product, hidden-bit weight at bit 20.
- in_zero  in  1  either operand zero.
- in_inf  in  1  either operand infinite (and neither is NaN).
- in_nan  in  1  NaN result, including inf*0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  16  binary16 result.
- out_flags  out  3  {overflow, underflow, inexact}.

Behaviour:
- Reset (rst=1 at clk edge): s1_valid=0, s2_valid=0, out_valid=0, out_data=16'h0000, out_flags=3'b000. Reset mid-operation discards in-flight items with no partial output.
- Handshake:
  - Transfer on in_valid&in_ready, or on out_valid&out_ready.
  - in_ready = ~s1_valid | s1_adv, where s1_adv = ~s2_valid | out_ready.
  - Stage 2 loads when s1_valid & s1_adv.
  - out_valid/out_data/out_flags hold stable while out_valid & ~out_ready.
  - No combinational path from in_valid to out_valid.
- Latency: exactly 2 cycles from accept to out_valid when not stalled. Full throughput of 1/cycle.
- Stage 1 (normalize):
  - If mant[21]=1: shift right 1 and exp+1.
  - frac = next 10 bits below hidden bit; G = next bit; S = OR of all remaining bits.
  - Biased exponent e = exp + BIAS (+1 if shifted), computed at EXP_W+1 bits signed.
- Stage 2 (round, RNE):
  - Round up iff G & (S | frac[0]).
  - Carry out of frac increments e and zeroes frac.
  - inexact = G|S.
- Range handling:
  - e >= 31: result is sign|16'h7C00, overflow=1, inexact=1.
  - e <= 0: result is signed zero, underflow=1, inexact=1 (unless SUBNORMAL_EN).
- Specials (priority nan > inf > zero, overriding arithmetic; flags 000):
  - nan: 16'h7E00.
  - inf: sign|7C00.
  - zero: sign<<15.
- Simultaneous accept and emit in the same cycle is legal and loses nothing. Output order equals input order.

Optional Feature:
- FP16_SUBNORMAL_EN defined:
  - When e <= 0, shift {1,frac,G} right by (1-e), capped at 12; shifted-out bits fold into S.
  - Round RNE; exponent field 0. A rounding carry into bit 10 yields exponent 1.
  - underflow=1 only if the result is inexact.
- Undefined: flush-to-zero as above. The shifter is not synthesized.

Decomposition:
- Package fp16_pkg: BIAS, EXP_MAX=31, QNAN=16'h7E00, INF=16'h7C00, flag bit indices, MANT_W/EXP_W constants.
- One combinational sub-module, fp16_round_rne: inputs {frac,G,S}, outputs {frac_rounded, carry, inexact}. Shared with future adder stage.

Test Plan:
- mant=0x100000, exp=0, sign=0 -> out_data 0x3C00, flags 000, out_valid exactly 2 cycles after accept.
- mant=0x240000 (1.5*1.5), exp=0 -> 0x4080, flags 000.
- Tie-to-even:
  - mant=0x100200 -> 0x3C00, inexact.
  - mant=0x100600 -> 0x3C02, inexact.
  - mant=0x1FFE00 -> 0x4000 (carry into exponent), inexact.
- Range:
  - exp=+16, mant=0x100000 -> 0x7C00, flags 101.
  - exp=-15 -> 0x0000, flags 011 (without FP16_SUBNORMAL_EN). With it: 0x0200, flags 000.
- Specials with sign=1: in_nan -> 0x7E00; in_inf -> 0xFC00; in_zero -> 0x8000; all flags 000.
- Backpressure: stream 5 products back-to-back while out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepts.
  - out_data held stable while stalled.
  - All 5 results emerge in order.
  - Assert rst mid-stream -> out_valid=0 the next cycle, nothing stale emitted.

Source files
------------

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared constants and types for the binary16 multiplier back end.
// Used by fp16_norm_round and fp16_round_rne.
package fp16_pkg;

  // Raw product format from the multiplier array
  localparam int MANT_W = 22;   // 11b x 11b significand product, format 2.20
  localparam int EXP_W  = 7;    // signed unbiased exponent sum

  // binary16 encoding
  localparam int          BIAS    = 15;
  localparam int          EXP_MAX = 31;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] INF     = 16'h7C00;

  // out_flags bit positions: {overflow, underflow, inexact}
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  // Normalized product held between stage 1 and stage 2
  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   e;      // biased exponent, two's complement
    logic [9:0]       frac;
    logic             g;
    logic             s;
    logic             zero;
    logic             inf;
    logic             nan;
  } s1_t;

endpackage

// File: rtl/fp16_norm_round_if.sv
// fp16_norm_round_if: product-in / result-out bus of the fp16 normalize+round stage.
//
// Handshake: each side is strict valid/ready. A beat transfers on a rising
// clk edge where valid & ready are both high. A producer holding valid must
// keep its payload stable until the transfer; ready may depend on the
// consumer's own state but never on the valid it is being offered.
interface fp16_norm_round_if;
  import fp16_pkg::*;

  // upstream product
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              in_zero;
  logic              in_inf;
  logic              in_nan;

  // downstream result
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [2:0]        out_flags;

  // master: drives products and sinks results
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  // slave: the normalize/round block
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_zero, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/fp16_round_rne.sv
// fp16_round_rne: round-to-nearest-even of a 10-bit fraction with guard and
// sticky bits. Purely combinational; shared with the adder datapath.
module fp16_round_rne (
  input  logic [9:0] frac,
  input  logic       g,
  input  logic       s,
  output logic [9:0] frac_rounded,
  output logic       carry,
  output logic       inexact
);

  logic round_up;

  // Round up past the halfway point, or at exactly halfway when frac is odd
  always_comb begin
    round_up                = g & (s | frac[0]);
    {carry, frac_rounded}   = {1'b0, frac} + {10'b0, round_up};
    inexact                 = g | s;
  end

endmodule

// File: rtl/fp16_norm_round.sv
// fp16_norm_round: normalize, round (RNE) and pack a raw fp16 product.
// Two-stage pipeline, valid/ready on both sides, 2-cycle latency, 1/cycle.
// Optional macro FP16_SUBNORMAL_EN: produce subnormal results instead of
// flushing tiny results to signed zero.
module fp16_norm_round
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fp16_norm_round_if.slave  bus
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_adv;
  s1_t         s1_d;
  s1_t         s1_q;
  logic [15:0] data_q;
  logic [2:0]  flags_q;

  // Stage 1 may hand its item on whenever stage 2 is empty or draining
  assign s1_adv        = ~s2_valid | bus.out_ready;
  assign bus.in_ready  = ~s1_valid | s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = data_q;
  assign bus.out_flags = flags_q;

  // Stage 1: bring the product into 1.xxx form and split frac / guard / sticky
  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.in_sign;
    s1_d.zero = bus.in_zero;
    s1_d.inf  = bus.in_inf;
    s1_d.nan  = bus.in_nan;
    s1_d.e    = {bus.in_exp[EXP_W-1], bus.in_exp} + (EXP_W+1)'(BIAS)
              + {{EXP_W{1'b0}}, bus.in_mant[21]};
    if (bus.in_mant[21]) begin
      s1_d.frac = bus.in_mant[20:11];
      s1_d.g    = bus.in_mant[10];
      s1_d.s    = |bus.in_mant[9:0];
    end else begin
      s1_d.frac = bus.in_mant[19:10];
      s1_d.g    = bus.in_mant[9];
      s1_d.s    = |bus.in_mant[8:0];
    end
  end

  // Stage 2 datapath
  logic           tiny;
  logic [9:0]     rf;
  logic           rg;
  logic           rs;
  logic [9:0]     fr;
  logic           carry;
  logic           inx;
  logic [EXP_W:0] e_r;
  logic [15:0]    res_data;
  logic [2:0]     res_flags;

  // Biased exponent at or below zero: result lies below the normal range
  assign tiny = s1_q.e[EXP_W] | (s1_q.e == '0);

`ifdef FP16_SUBNORMAL_EN
  logic [EXP_W:0] amt;
  logic [3:0]     sh;
  logic [23:0]    wide;

  // Denormalize tiny results: shift {1,frac,G} right by 1-e, lost bits join sticky
  always_comb begin
    amt  = (EXP_W+1)'(1) - s1_q.e;
    sh   = (amt > (EXP_W+1)'(12)) ? 4'd12 : amt[3:0];
    wide = {1'b1, s1_q.frac, s1_q.g, 12'b0} >> sh;
    if (tiny) begin
      rf = wide[22:13];
      rg = wide[12];
      rs = s1_q.s | (|wide[11:0]);
    end else begin
      rf = s1_q.frac;
      rg = s1_q.g;
      rs = s1_q.s;
    end
  end
`else
  assign rf = s1_q.frac;
  assign rg = s1_q.g;
  assign rs = s1_q.s;
`endif

  fp16_round_rne u_round (
    .frac         (rf),
    .g            (rg),
    .s            (rs),
    .frac_rounded (fr),
    .carry        (carry),
    .inexact      (inx)
  );

  assign e_r = s1_q.e + {{EXP_W{1'b0}}, carry};

  // Stage 2: specials first, then range handling, then the normal packing
  always_comb begin
    res_data  = '0;
    res_flags = '0;
    if (s1_q.nan) begin
      res_data = QNAN;
    end else if (s1_q.inf) begin
      res_data = {s1_q.sign, INF[14:0]};
    end else if (s1_q.zero) begin
      res_data = {s1_q.sign, 15'h0000};
    end else if (tiny) begin
`ifdef FP16_SUBNORMAL_EN
      // a carry out of the fraction lands exactly on the smallest normal
      res_data            = {s1_q.sign, 4'b0000, carry, fr};
      res_flags[FLAG_UNF] = inx;
      res_flags[FLAG_INX] = inx;
`else
      res_data            = {s1_q.sign, 15'h0000};
      res_flags[FLAG_UNF] = 1'b1;
      res_flags[FLAG_INX] = 1'b1;
`endif
    end else if ($signed(e_r) >= $signed((EXP_W+1)'(EXP_MAX))) begin
      res_data            = {s1_q.sign, INF[14:0]};
      res_flags[FLAG_OVF] = 1'b1;
      res_flags[FLAG_INX] = 1'b1;
    end else begin
      res_data            = {s1_q.sign, e_r[4:0], fr};
      res_flags[FLAG_INX] = inx;
    end
  end

  // Pipeline registers: stage 1 loads on accept, stage 2 loads on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      data_q   <= '0;
      flags_q  <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (bus.in_valid && bus.in_ready) s1_q <= s1_d;
      if (s1_adv) s2_valid <= s1_valid;
      if (s1_valid && s1_adv) begin
        data_q  <= res_data;
        flags_q <= res_flags;
      end
    end
  end

endmodule
